// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared state type, default timing and helpers for the SPI byte receiver
package spi_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  localparam int BIT_DIV_DEFAULT = 34;

  // Value the counter sequence must take on the byte following prev.
  function automatic logic [7:0] next_expected(input logic [7:0] prev);
    return prev + 8'd1;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// rtl/spi_bit_timer.sv - bit/byte timing for the SPI byte receiver
// Counts sclk cycles within a serial bit and bits within a byte; strobes are combinational.
module spi_bit_timer
  import spi_rx_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEFAULT
) (
  input  logic sclk,
  input  logic reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_sample_tick,
  output logic o_bit_end,
  output logic o_byte_end
);

  localparam int DIV_W = $clog2(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(BIT_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_idx;

  // bit_idx wraps 7 -> 0 by its width, so back-to-back bytes need no extra restart.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_bit_idx <= 3'd0;
    end else if (i_start) begin
      r_div     <= '0;
      r_bit_idx <= 3'd0;
    end else if (i_run) begin
      if (r_div == DIV_LAST) begin
        r_div     <= '0;
        r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_sample_tick = i_run && (r_div == DIV_MID);
  assign o_bit_end     = i_run && (r_div == DIV_LAST);
  assign o_byte_end    = o_bit_end && (r_bit_idx == 3'd7);

endmodule

// File: rtl/spi_byte_receiver.sv
// rtl/spi_byte_receiver.sv - oversampling LSB-first SPI byte receiver with valid/ready output
// Also checks that successive bytes count upward and keeps sticky overrun/error statistics.
module spi_byte_receiver
  import spi_rx_pkg::*;
#(
  parameter int BIT_DIV   = BIT_DIV_DEFAULT,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        mosi,
  input  logic        cs,
  input  logic        rx_ready,
  input  logic        clr_err,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        overrun,
  output logic        seq_err,
  output logic [15:0] err_count
);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic       r_cs_d;
  logic [7:0] r_shreg;
  logic [7:0] r_last;
  logic       r_have_last;

  logic w_start;
  logic w_run;
  logic w_sample_tick;
  logic w_bit_end;
  logic w_byte_end;
  logic w_byte_done;
  logic w_mismatch;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cs_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs_d  <= cs;
    end
  end

  // Dropping cs in SHIFT aborts at once; the timer is simply frozen and restarted next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cs && !r_cs_d) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs) begin
          w_run = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  spi_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .sclk         (sclk),
    .reset        (reset),
    .i_start      (w_start),
    .i_run        (w_run),
    .o_sample_tick(w_sample_tick),
    .o_bit_end    (w_bit_end),
    .o_byte_end   (w_byte_end)
  );

  assign w_byte_done = w_bit_end && w_byte_end;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_shreg <= 8'h00;
    end else if (w_sample_tick) begin
      r_shreg <= {mosi, r_shreg[7:1]};
    end
  end

  // A byte finishing while the previous one is still unaccepted is dropped, not queued.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign w_mismatch = SEQ_CHECK && r_have_last && (r_shreg != next_expected(r_last));

  // clr_err outranks a coincident byte: no pulse, no count, and that byte does not seed history.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_last      <= 8'h00;
      r_have_last <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= 16'h0000;
    end else begin
      seq_err <= 1'b0;
      if (clr_err) begin
        r_have_last <= 1'b0;
        err_count   <= 16'h0000;
      end else if (w_byte_done) begin
        r_last      <= r_shreg;
        r_have_last <= 1'b1;
        if (w_mismatch) begin
          seq_err <= 1'b1;
          if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// tb/tb_spi_byte_receiver.sv - self-checking bench for spi_byte_receiver
module tb_spi_byte_receiver;

  localparam int BD = 4;

  logic        sclk = 1'b0;
  logic        reset;
  logic        mosi;
  logic        cs;
  logic        rx_ready;
  logic        clr_err;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        overrun;
  logic        seq_err;
  logic [15:0] err_count;

  spi_byte_receiver #(
    .BIT_DIV  (BD),
    .SEQ_CHECK(1'b1)
  ) dut (
    .sclk     (sclk),
    .reset    (reset),
    .mosi     (mosi),
    .cs       (cs),
    .rx_ready (rx_ready),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .seq_err  (seq_err),
    .err_count(err_count)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fails  = 0;

  // Transaction-level expectation of the receiver's visible state.
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_overrun;
  logic        m_seq;
  logic [15:0] m_errs;
  logic        m_have;
  logic [7:0]  m_last;

  bit          rnd_ready;
  bit          rnd_clr;
  bit          done_flag;
  logic [7:0]  done_byte;
  int          vcount;
  int          scount;
  logic [7:0]  tx_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_overrun = 1'b0;
    m_seq     = 1'b0;
    m_errs    = 16'h0000;
    m_have    = 1'b0;
    m_last    = 8'h00;
  endtask

  task automatic model_edge(input logic rdy, input logic clr, input logic done, input logic [7:0] b);
    logic [7:0] want;
    want  = m_last + 8'd1;
    m_seq = 1'b0;
    if (done) begin
      if (!clr) begin
        if (m_have && (b != want)) begin
          m_seq = 1'b1;
          if (m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
        end
        m_last = b;
        m_have = 1'b1;
      end
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = b;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (clr) begin
      m_overrun = 1'b0;
      m_errs    = 16'h0000;
      m_have    = 1'b0;
    end
  endtask

  task automatic step();
    logic       rdy_s;
    logic       clr_s;
    logic       done_s;
    logic [7:0] b_s;
    if (rnd_ready) rx_ready = ($urandom_range(0, 3) != 0);
    if (rnd_clr)   clr_err  = ($urandom_range(0, 47) == 0);
    rdy_s     = rx_ready;
    clr_s     = clr_err;
    done_s    = done_flag;
    b_s       = done_byte;
    done_flag = 1'b0;
    @(posedge sclk);
    #1;
    model_edge(rdy_s, clr_s, done_s, b_s);
    if (rx_valid) vcount++;
    if (seq_err)  scount++;
    check("rx_valid",  rx_valid,  m_valid);
    check("rx_data",   rx_data,   m_data);
    check("overrun",   overrun,   m_overrun);
    check("seq_err",   seq_err,   m_seq);
    check("err_count", err_count, m_errs);
  endtask

  task automatic start_frame();
    cs = 1'b1;
    step();
  endtask

  task automatic end_frame();
    cs = 1'b0;
    step();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      mosi = b[k];
      for (int j = 0; j < BD; j++) begin
        if (n == 8 && k == 7 && j == BD - 1) begin
          done_flag = 1'b1;
          done_byte = b;
        end
        step();
      end
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    int  nb;
    bit  aborted;
    logic [7:0] b;

    reset     = 1'b1;
    cs        = 1'b0;
    mosi      = 1'b0;
    rx_ready  = 1'b1;
    clr_err   = 1'b0;
    rnd_ready = 1'b0;
    rnd_clr   = 1'b0;
    done_flag = 1'b0;
    done_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge sclk);
    #1;
    reset = 1'b0;
    check("reset_rx_data",   rx_data,   8'h00);
    check("reset_rx_valid",  rx_valid,  1'b0);
    check("reset_overrun",   overrun,   1'b0);
    check("reset_seq_err",   seq_err,   1'b0);
    check("reset_err_count", err_count, 16'h0000);

    // single byte
    vcount = 0;
    start_frame();
    send_bits(8'hA5, 8);
    check("single_data",  rx_data,  8'hA5);
    check("single_valid", rx_valid, 1'b1);
    step();
    check("single_one_cycle", vcount, 1);
    end_frame();

    // back-to-back bytes
    pulse_clr();
    vcount = 0;
    scount = 0;
    start_frame();
    send_bits(8'h01, 8);
    send_bits(8'h02, 8);
    send_bits(8'h03, 8);
    step();
    end_frame();
    check("b2b_pulses", vcount, 3);
    check("b2b_seq",    scount, 0);
    check("b2b_errs",   err_count, 16'd0);

    // sequence errors and wrap
    pulse_clr();
    scount = 0;
    start_frame();
    send_bits(8'h05, 8);
    send_bits(8'h07, 8);
    check("seq_errs_1",   err_count, 16'd1);
    check("seq_pulses_1", scount, 1);
    send_bits(8'hFF, 8);
    send_bits(8'h00, 8);
    end_frame();
    check("seq_errs_2",   err_count, 16'd2);
    check("seq_pulses_2", scount, 2);

    // backpressure
    rx_ready = 1'b0;
    start_frame();
    send_bits(8'h10, 8);
    send_bits(8'h11, 8);
    end_frame();
    check("bp_data",    rx_data,  8'h10);
    check("bp_valid",   rx_valid, 1'b1);
    check("bp_overrun", overrun,  1'b1);
    pulse_clr();
    check("clr_overrun", overrun,   1'b0);
    check("clr_errs",    err_count, 16'd0);
    check("clr_keeps_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    step();
    check("bp_drained", rx_valid, 1'b0);

    // abort after three bits, then a full frame
    vcount = 0;
    start_frame();
    send_bits(8'h5A, 3);
    end_frame();
    step();
    check("abort_no_valid", vcount, 0);
    rx_ready = 1'b0;
    start_frame();
    send_bits(8'h3C, 8);
    end_frame();
    check("after_abort_data",  rx_data,  8'h3C);
    check("after_abort_valid", rx_valid, 1'b1);

    // asynchronous reset mid-frame
    start_frame();
    send_bits(8'h81, 2);
    reset = 1'b1;
    #2;
    check("async_rx_data",   rx_data,   8'h00);
    check("async_rx_valid",  rx_valid,  1'b0);
    check("async_overrun",   overrun,   1'b0);
    check("async_seq_err",   seq_err,   1'b0);
    check("async_err_count", err_count, 16'h0000);
    model_reset();
    cs = 1'b0;
    #1;
    reset    = 1'b0;
    rx_ready = 1'b1;
    repeat (3) step();

    // randomized traffic: mostly counting bytes, random aborts, ready and clears
    rnd_ready = 1'b1;
    rnd_clr   = 1'b1;
    tx_next   = 8'($urandom);
    for (int it = 0; it < 60; it++) begin
      nb      = $urandom_range(1, 3);
      aborted = 1'b0;
      start_frame();
      for (int i = 0; i < nb; i++) begin
        if (!aborted) begin
          if ($urandom_range(0, 9) == 0) begin
            send_bits(8'($urandom), $urandom_range(1, 7));
            aborted = 1'b1;
          end else begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tx_next;
            send_bits(b, 8);
            tx_next = b + 8'd1;
          end
        end
      end
      end_frame();
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_ready = 1'b0;
    rnd_clr   = 1'b0;
    rx_ready  = 1'b1;
    clr_err   = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
